// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} fetch_state_t;

  localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
  localparam int          DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/fetch_line_buf.sv
// One-entry tagged instruction buffer: tag/data/valid registers plus the hit compare.
// Invalidate has priority over a write in the same cycle.
module fetch_line_buf (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] lookup_tag,
  input  logic        wr_en,
  input  logic [29:0] wr_tag,
  input  logic [31:0] wr_data,
  input  logic        inv,
  output logic [31:0] rd_data,
  output logic        hit
);
  logic [29:0] tag_q, tag_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_en) begin
      tag_d   = wr_tag;
      data_d  = wr_data;
      valid_d = 1'b1;
    end
    if (inv) valid_d = 1'b0;
  end

  assign rd_data = data_q;
  assign hit     = valid_q && (tag_q == lookup_tag);
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: req/ack bus master with a one-entry tagged buffer.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic              fetch_en,
  input  logic              flush,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              fetch_err
);
  fetch_state_t state_q, state_d;
  logic [29:0]  req_addr_q, req_addr_d;
  logic         mem_req_q, mem_req_d;
  logic         discard_q, discard_d;
  logic         hit;
  logic         expire;
  logic         buf_wr;
  logic [31:0]  buf_wr_data;
  logic         unused_bits;

  assign unused_bits = ^pc[1:0];

  fetch_line_buf u_buf (
    .clock      (clock),
    .reset      (reset),
    .lookup_tag (pc[31:2]),
    .wr_en      (buf_wr),
    .wr_tag     (req_addr_q),
    .wr_data    (buf_wr_data),
    .inv        (flush),
    .rd_data    (instruction),
    .hit        (hit)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Counter is zero in the first REQ cycle, so expiry lands on the TIMEOUT-th REQ cycle.
  always_comb begin
    cnt_d  = '0;
    expire = 1'b0;
    if (state_q == REQ) begin
      cnt_d  = cnt_q + 1'b1;
      expire = !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
    end
    err_d = err_q | expire;
  end

  assign fetch_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign expire         = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      mem_req_q  <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      mem_req_q  <= mem_req_d;
      discard_q  <= discard_d;
    end
  end

  // A started request runs to ack (or expiry) regardless of pc; flush only marks it for discard.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    mem_req_d  = mem_req_q;
    discard_d  = discard_q;
    case (state_q)
      IDLE: begin
        if (fetch_en && !hit && !flush) begin
          req_addr_d = pc[31:2];
          mem_req_d  = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem_ack || expire) begin
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          state_d   = IDLE;
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_wr      = 1'b0;
    buf_wr_data = mem_rdata;
    if (state_q == REQ && !discard_q && !flush) begin
      if (mem_ack) begin
        buf_wr = 1'b1;
      end else if (expire) begin
        buf_wr      = 1'b1;
        buf_wr_data = NOP_WORD;
      end
    end
    instr_valid = fetch_en & hit;
    stall       = fetch_en & ~hit;
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = req_addr_q[ADDR_W-1:0];
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage feeding the single-cycle datapath's `instruction` and consuming its `pc`. Fetches 32-bit words from an external instruction memory over a req/ack handshake. Holds the last fetched word in a one-entry tagged buffer. Asserts `stall` to freeze the core's PC register until the word for the current `pc` is available.

## Interface
Parameters:
- `ADDR_W`, default 30: word-address width on the memory bus.
- `TIMEOUT`, default 255: max cycles to wait for `mem_ack`. Used only with `FETCH_TIMEOUT_EN`.

Ports:
- `clock` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `pc` input 32: byte address of the instruction the core wants; `pc[1:0]` are ignored.
- `fetch_en` input 1: the core requests the instruction at `pc` this cycle.
- `flush` input 1: invalidates the buffer and discards any in-flight response.
- `instruction` output 32: buffered instruction word.
- `instr_valid` output 1: `instruction` corresponds to the current `pc`.
- `stall` output 1: the core must hold its PC.
- `mem_req` output 1: bus read request.
- `mem_addr` output ADDR_W: word address, `req_addr[ADDR_W+1:2]`.
- `mem_ack` input 1: read data valid; may be high in the same cycle as `mem_req`.
- `mem_rdata` input 32: read data, sampled when `mem_ack` is high.
- `fetch_err` output 1: sticky timeout flag.

## Operation
Buffer registers:
- `buf_addr[31:2]`, `buf_data[31:0]`, `buf_valid`.
- `hit = buf_valid & (buf_addr == pc[31:2])`, combinational.

Outputs:
- `instruction = buf_data`.
- `instr_valid = fetch_en & hit`.
- `stall = fetch_en & ~hit`.

FSM with states IDLE and REQ:
- **IDLE**
  - If `fetch_en & ~hit & ~flush`: latch `req_addr <= pc[31:2]`, set `mem_req <= 1`, go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `mem_req` and `mem_addr` are held stable until `mem_ack`. A started transaction is never aborted by a `pc` change.
  - On `mem_ack`:
    - `mem_req <= 0`, go to IDLE.
    - If no discard is pending and `flush` is low: `buf_addr <= req_addr`, `buf_data <= mem_rdata`, `buf_valid <= 1`.
    - Otherwise the buffer is not written.
  - If `pc` changed during REQ, the old word is still written under its own tag. The following IDLE cycle sees a miss and refetches.

Flush:
- `flush` clears `buf_valid` on the next edge, in any state.
- `flush` in REQ sets `discard`. The eventual response is dropped, and `discard` clears on that ack.
- `flush` and `mem_ack` in the same cycle: the response is dropped.

Other rules:
- `fetch_en` low: no new request is issued. `stall` and `instr_valid` are 0.

## Timing
Reset values:
- `mem_req` = 0, `mem_addr` = 0, `instruction` = 0, `buf_valid` = 0, `fetch_err` = 0, state = IDLE, `discard` = 0.
- Immediately after reset, `stall` equals `fetch_en`.

Latency:
- Hit: `instr_valid` in the same cycle, zero latency.
- Miss detected in cycle N: `mem_req` rises in N+1. With ack in N+1, `instr_valid` is high in N+2, so the minimum miss penalty is 2 cycles.
- Each cycle of ack delay adds one cycle.

Reset mid-REQ: `mem_req` drops asynchronously. The bus must tolerate an abandoned request.

## Configuration
`FETCH_TIMEOUT_EN` defined:
- An 8-bit+ counter (`$clog2(TIMEOUT+1)` bits) runs in REQ and clears on entry.
- When the count reaches `TIMEOUT` without an ack:
  - `mem_req <= 0`, go to IDLE.
  - The buffer is loaded with `NOP_WORD` (32'h0000_0000) tagged `req_addr`, unless a discard is pending.
  - `fetch_err` is set and stays set until reset.
- An ack in the same cycle as expiry wins; no error is raised.

`FETCH_TIMEOUT_EN` undefined:
- No counter; REQ waits indefinitely.
- `fetch_err` is tied to 0.

## Structure
Package `fetch_pkg` holds:
- `typedef enum logic {IDLE, REQ} fetch_state_t`.
- `NOP_WORD`.
- `DEFAULT_TIMEOUT`.

Sub-module `fetch_line_buf` holds the tag, data and valid registers and the hit compare, with write and invalidate ports. The FSM, the timeout logic and the bus handshake stay in `instr_fetch_unit`.

## Test plan
- **Cold miss:** after reset, `pc`=0x0000_0040, `fetch_en`=1, zero-wait ack with `mem_rdata`=0x2008_0005.
  - `mem_req` in cycle 1 with `mem_addr`=0x10.
  - `instr_valid`=1 with `instruction`=0x2008_0005 in cycle 2.
  - `stall`=1 in cycles 0–1.
- **Hit:** hold `pc`=0x40. Expect `instr_valid`=1, `stall`=0 and no `mem_req` for 10 cycles.
- **Wait states and pc change:** ack delayed 3 cycles, `pc` changes to 0x44 during REQ.
  - `mem_addr` stays 0x10 until the ack.
  - The buffer is tagged 0x40.
  - A new request to 0x11 is issued the next cycle.
- **Flush:**
  - `flush` in REQ with ack 2 cycles later: no `instr_valid`, and a refetch of the same `pc` follows.
  - `flush` coincident with the ack: the response is dropped.
- **Timeout (`FETCH_TIMEOUT_EN`, `TIMEOUT`=4):** never ack.
  - `mem_req` drops after 4 REQ cycles.
  - `instruction`=0x0, `instr_valid`=1, `fetch_err`=1, and `fetch_err` stays set.
- **Async reset:** assert `reset` mid-REQ. `mem_req`, `buf_valid` and `fetch_err` go to 0 immediately, without waiting for a clock edge.
